// File: rtl/line_buf_rd_ctrl_if.sv
// rtl/line_buf_rd_ctrl_if.sv - frame control, writer handshake and window read bundle for line_buf_rd_ctrl
interface line_buf_rd_ctrl_if #(
    parameter int addr_width = 5
);
    logic                  start;
    logic                  line_done;
    logic                  win_ready;
    logic [3:0]            rden;
    logic [addr_width-1:0] rd_addr;
    logic [1:0]            top_sel;
    logic [1:0]            mid_sel;
    logic [1:0]            bot_sel;
    logic                  de_out;
    logic [addr_width-1:0] col;
    logic [4:0]            out_row;
    logic [2:0]            pad_mask;
    logic                  wr_stall;
    logic                  busy;
    logic                  frame_done;
    logic                  overflow;

    modport master (
        input  start, line_done, win_ready,
        output rden, rd_addr, top_sel, mid_sel, bot_sel, de_out, col, out_row,
               pad_mask, wr_stall, busy, frame_done, overflow
    );

    modport slave (
        output start, line_done, win_ready,
        input  rden, rd_addr, top_sel, mid_sel, bot_sel, de_out, col, out_row,
               pad_mask, wr_stall, busy, frame_done, overflow
    );
endinterface

// File: rtl/line_buf_rd_ctrl.sv
// rtl/line_buf_rd_ctrl.sv - read sequencer for the 4-bank rotating line buffer feeding the 3x3 window
// Optional zero padding (same-size output) is enabled by defining LBUF_PAD_EN.
module line_buf_rd_ctrl #(
    parameter int image_width  = 28,
    parameter int image_height = 28,
    parameter int addr_width   = 5
) (
    input  logic               clk,
    input  logic               RESET,
    line_buf_rd_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, WAIT, READ, ADV, DONE} state_t;

    localparam logic [4:0]            height   = 5'(image_height);
    localparam logic [addr_width-1:0] last_col = addr_width'(image_width - 1);
`ifdef LBUF_PAD_EN
    localparam logic [6:0]            height_x = 7'(image_height);
    localparam logic [4:0]            n_rows   = 5'(image_height);
`else
    localparam logic [4:0]            n_rows   = 5'(image_height - 2);
`endif

    state_t                state, state_nxt;
    logic [4:0]            wr_rows, rd_row;
    logic [addr_width-1:0] rd_addr;
    logic                  overflow;
    logic                  de_q;
    logic [addr_width-1:0] col_q;
    logic [1:0]            top_q, mid_q, bot_q;
    logic [4:0]            out_row_q;
    logic [2:0]            pad_q;

    logic [6:0]            wr_x, rd_x, need, stall_lim;
    logic [1:0]            top_b, mid_b, bot_b;
    logic [2:0]            pad;
    logic [3:0]            win_bits;
    logic [3:0]            rden;
    logic                  frame_done;
    logic                  busy, wr_stall, go, start_frame;

    // Comparisons run at 7 bits so rd_row + 4 can never wrap.
    assign wr_x = {2'b00, wr_rows};
    assign rd_x = {2'b00, rd_row};

`ifdef LBUF_PAD_EN
    assign need      = (rd_x + 7'd2 < height_x) ? rd_x + 7'd2 : height_x;
    assign stall_lim = rd_x + 7'd3;
    assign top_b     = rd_row[1:0] - 2'd1;
    assign mid_b     = rd_row[1:0];
    assign bot_b     = rd_row[1:0] + 2'd1;
    assign pad       = {rd_row == 5'd0, 1'b0, rd_row == height - 5'd1};
`else
    assign need      = rd_x + 7'd3;
    assign stall_lim = rd_x + 7'd4;
    assign top_b     = rd_row[1:0];
    assign mid_b     = rd_row[1:0] + 2'd1;
    assign bot_b     = rd_row[1:0] + 2'd2;
    assign pad       = 3'b000;
`endif

    // A padded window row substitutes zeros, so its bank is left unread.
    assign win_bits = (pad[2] ? 4'b0000 : (4'b0001 << top_b))
                    | (4'b0001 << mid_b)
                    | (pad[0] ? 4'b0000 : (4'b0001 << bot_b));

    assign busy        = (state != IDLE);
    assign wr_stall    = busy && ((wr_x >= stall_lim) || (wr_rows == height));
    assign start_frame = (state == IDLE) && bus.start;
    assign go          = (wr_x >= need) && bus.win_ready;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rden       = 4'b0000;
        frame_done = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = WAIT;
            WAIT: if (go) state_nxt = READ;
            READ: begin
                rden = win_bits;
                if (rd_addr == last_col) state_nxt = ADV;
            end
            ADV:  state_nxt = (rd_row + 5'd1 == n_rows) ? DONE : WAIT;
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wr_rows   <= 5'd0;
            rd_row    <= 5'd0;
            rd_addr   <= '0;
            overflow  <= 1'b0;
            de_q      <= 1'b0;
            col_q     <= '0;
            top_q     <= 2'd0;
            mid_q     <= 2'd0;
            bot_q     <= 2'd0;
            out_row_q <= 5'd0;
            pad_q     <= 3'b000;
        end else begin
            if (start_frame) begin
                wr_rows <= 5'd0;
            end else if (bus.line_done && (wr_rows != height)) begin
                wr_rows <= wr_rows + 5'd1;
            end

            if (start_frame) begin
                overflow <= 1'b0;
            end else if (bus.line_done && wr_stall) begin
                overflow <= 1'b1;
            end

            if (start_frame) begin
                rd_row <= 5'd0;
            end else if (state == ADV) begin
                rd_row <= rd_row + 5'd1;
            end

            if (state == WAIT) begin
                rd_addr <= '0;
            end else if (state == READ) begin
                rd_addr <= (rd_addr == last_col) ? '0 : rd_addr + 1'b1;
            end

            // Window sideband follows rden by one cycle to line up with BRAM q.
            de_q      <= (state == READ);
            col_q     <= rd_addr;
            top_q     <= top_b;
            mid_q     <= mid_b;
            bot_q     <= bot_b;
            out_row_q <= rd_row;
            pad_q     <= (state == READ) ? pad : 3'b000;
        end
    end

    assign bus.rden       = rden;
    assign bus.rd_addr    = rd_addr;
    assign bus.top_sel    = top_q;
    assign bus.mid_sel    = mid_q;
    assign bus.bot_sel    = bot_q;
    assign bus.de_out     = de_q;
    assign bus.col        = col_q;
    assign bus.out_row    = out_row_q;
    assign bus.pad_mask   = pad_q;
    assign bus.wr_stall   = wr_stall;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_line_buf_rd_ctrl.sv
// tb/tb_line_buf_rd_ctrl.sv - directed self-checking bench for line_buf_rd_ctrl
module tb_line_buf_rd_ctrl;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int AW = 5;
`ifdef LBUF_PAD_EN
    localparam int N_OUT      = H;
    localparam int TOP_OFS    = 3;
    localparam int FIRST_NEED = 2;
    localparam logic [3:0] ROW3_RDEN = 4'b1101;
`else
    localparam int N_OUT      = H - 2;
    localparam int TOP_OFS    = 0;
    localparam int FIRST_NEED = 3;
    localparam logic [3:0] ROW3_RDEN = 4'b1011;
`endif

    logic clk   = 1'b0;
    logic RESET = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    line_buf_rd_ctrl_if #(.addr_width(AW)) bus ();

    line_buf_rd_ctrl #(
        .image_width (W),
        .image_height(H),
        .addr_width  (AW)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.line_done = 1'b0; bus.win_ready = 1'b0;
        RESET = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.rden, bus.de_out, bus.busy, bus.wr_stall, bus.overflow, bus.frame_done} !== 10'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {bus.rden, bus.de_out, bus.busy, bus.wr_stall, bus.overflow, bus.frame_done});
        end
        n_checks++;
        if ({bus.rd_addr, bus.col, bus.out_row, bus.top_sel, bus.mid_sel, bus.bot_sel, bus.pad_mask} !== 24'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.rd_addr, bus.col, bus.out_row, bus.top_sel, bus.mid_sel, bus.bot_sel, bus.pad_mask});
        end
        RESET = 1'b1;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_full_frame();
        int cyc = 0, ld_sent = 0, de_cnt = 0, rden_cyc = 0, fd_cnt = 0, r, need;
        bit fin = 0, ovf_checked = 0;
        logic [3:0] prev_rden = 4'b0, exp_rden, row3_rden = 4'b0;
        logic [2:0] exp_pad;
        bus.win_ready = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL start_busy: got %b expected 1", bus.busy);
        end
        while (!fin && cyc < 3000) begin
            if (bus.rden !== 4'b0) begin
                r = rden_cyc / W;
                exp_rden = 4'b1111 & ~(4'b0001 << ((r + TOP_OFS + 3) % 4));
`ifdef LBUF_PAD_EN
                if (r == 0) exp_rden = exp_rden & ~(4'b0001 << ((r + 3) % 4));
                if (r == H - 1) exp_rden = exp_rden & ~(4'b0001 << ((r + 1) % 4));
`endif
                n_checks++;
                if (bus.rden !== exp_rden) begin
                    n_fail++; $display("FAIL rden_row%0d: got %b expected %b", r, bus.rden, exp_rden);
                end
                n_checks++;
                if (bus.rd_addr !== AW'(rden_cyc % W)) begin
                    n_fail++; $display("FAIL rd_addr_row%0d: got %0d expected %0d", r, bus.rd_addr, rden_cyc % W);
                end
                need = (r + FIRST_NEED > H) ? H : r + FIRST_NEED;
                n_checks++;
                if (ld_sent < need) begin
                    n_fail++; $display("FAIL read_early_row%0d: got %0d rows written expected >= %0d", r, ld_sent, need);
                end
                if (r == 3 && rden_cyc % W == 0) row3_rden = bus.rden;
                rden_cyc++;
            end
            n_checks++;
            if (bus.de_out !== (prev_rden != 4'b0)) begin
                n_fail++; $display("FAIL de_align: got %b expected %b", bus.de_out, prev_rden != 4'b0);
            end
            if (bus.de_out === 1'b1) begin
                r = de_cnt / W;
`ifdef LBUF_PAD_EN
                exp_pad = {r == 0, 1'b0, r == H - 1};
`else
                exp_pad = 3'b000;
`endif
                n_checks++;
                if ({bus.col, bus.out_row} !== {AW'(de_cnt % W), 5'(r)}) begin
                    n_fail++; $display("FAIL col_row: got col %0d row %0d expected col %0d row %0d", bus.col, bus.out_row, de_cnt % W, r);
                end
                n_checks++;
                if ({bus.top_sel, bus.mid_sel, bus.bot_sel} !== {2'((r + TOP_OFS) % 4), 2'((r + TOP_OFS + 1) % 4), 2'((r + TOP_OFS + 2) % 4)}) begin
                    n_fail++; $display("FAIL sels_row%0d: got %0d %0d %0d", r, bus.top_sel, bus.mid_sel, bus.bot_sel);
                end
                n_checks++;
                if (bus.pad_mask !== exp_pad) begin
                    n_fail++; $display("FAIL pad_mask_row%0d: got %b expected %b", r, bus.pad_mask, exp_pad);
                end
                de_cnt++;
            end
            if (bus.frame_done === 1'b1) begin
                fd_cnt++;
                fin = 1;
                n_checks++;
                if (bus.busy !== 1'b1) begin
                    n_fail++; $display("FAIL done_busy: got %b expected 1", bus.busy);
                end
            end
            prev_rden = bus.rden;
            if (ld_sent == 28 && !ovf_checked) begin
                ovf_checked = 1;
                n_checks++;
                if (bus.overflow !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_normal: got %b expected 0", bus.overflow);
                end
            end
            bus.line_done = ((cyc % 30 == 29) && ld_sent < 28) || (cyc == 849);
            if (bus.line_done) ld_sent++;
            tick();
            cyc++;
        end
        bus.line_done = 1'b0;
        repeat (5) begin
            if (bus.frame_done === 1'b1) fd_cnt++;
            tick();
        end
        n_checks++;
        if (fd_cnt !== 1) begin
            n_fail++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt);
        end
        n_checks++;
        if (de_cnt !== N_OUT * W) begin
            n_fail++; $display("FAIL de_total: got %0d expected %0d", de_cnt, N_OUT * W);
        end
        n_checks++;
        if (row3_rden !== ROW3_RDEN) begin
            n_fail++; $display("FAIL rden_row3: got %b expected %b", row3_rden, ROW3_RDEN);
        end
        n_checks++;
        if ({bus.busy, bus.wr_stall, bus.overflow} !== 3'b001) begin
            n_fail++; $display("FAIL post_frame: got busy/stall/ovf %b expected 001", {bus.busy, bus.wr_stall, bus.overflow});
        end
    endtask

`ifndef LBUF_PAD_EN
    task automatic test_backpressure_and_reset();
        logic [3:0] any_rden = 4'b0;
        int k = 0;
        bus.win_ready = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.overflow, bus.wr_stall} !== 3'b100) begin
            n_fail++; $display("FAIL start_clears: got busy/ovf/stall %b expected 100", {bus.busy, bus.overflow, bus.wr_stall});
        end
        repeat (3) begin
            bus.line_done = 1'b1; tick(); bus.line_done = 1'b0; tick();
        end
        repeat (20) begin
            tick();
            any_rden = any_rden | bus.rden;
        end
        n_checks++;
        if ({any_rden, bus.wr_stall} !== 5'b0) begin
            n_fail++; $display("FAIL hold_no_read: got rden %b stall %b expected 0 0", any_rden, bus.wr_stall);
        end
        bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
        n_checks++;
        if ({bus.wr_stall, bus.overflow} !== 2'b10) begin
            n_fail++; $display("FAIL stall_at_4: got stall/ovf %b expected 10", {bus.wr_stall, bus.overflow});
        end
        bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.overflow);
        end
        bus.win_ready = 1'b1; tick();
        n_checks++;
        if ({bus.rden, bus.rd_addr} !== {4'b0111, 5'd0}) begin
            n_fail++; $display("FAIL resume_rden: got %b addr %0d expected 0111 addr 0", bus.rden, bus.rd_addr);
        end
        bus.win_ready = 1'b0; tick();
        n_checks++;
        if ({bus.de_out, bus.out_row, bus.col, bus.top_sel, bus.mid_sel, bus.bot_sel} !== {1'b1, 5'd0, 5'd0, 2'd0, 2'd1, 2'd2}) begin
            n_fail++; $display("FAIL resume_de: got de %b row %0d col %0d sels %0d %0d %0d expected 1 0 0 0 1 2", bus.de_out, bus.out_row, bus.col, bus.top_sel, bus.mid_sel, bus.bot_sel);
        end
        while (bus.rd_addr !== 5'd10 && k < 40) begin
            tick(); k++;
        end
        n_checks++;
        if ({bus.rden, bus.rd_addr} !== {4'b0111, 5'd10}) begin
            n_fail++; $display("FAIL read_continues: got %b addr %0d expected 0111 addr 10", bus.rden, bus.rd_addr);
        end
        #1 RESET = 1'b0;
        #1;
        n_checks++;
        if ({bus.rden, bus.de_out, bus.busy, bus.wr_stall, bus.overflow, bus.frame_done} !== 10'd0) begin
            n_fail++; $display("FAIL midreset_ctrl: got %b expected 0", {bus.rden, bus.de_out, bus.busy, bus.wr_stall, bus.overflow, bus.frame_done});
        end
        n_checks++;
        if ({bus.rd_addr, bus.col, bus.out_row, bus.top_sel, bus.mid_sel, bus.bot_sel, bus.pad_mask} !== 24'd0) begin
            n_fail++; $display("FAIL midreset_data: got %h expected 0", {bus.rd_addr, bus.col, bus.out_row, bus.top_sel, bus.mid_sel, bus.bot_sel, bus.pad_mask});
        end
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_coincident();
        int k = 0;
        bus.win_ready = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (3) begin
            bus.line_done = 1'b1; tick(); bus.line_done = 1'b0; tick();
        end
        while (!(bus.rden !== 4'b0 && bus.rd_addr === 5'(W - 1)) && k < 200) begin
            tick(); k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++; $display("FAIL coin_row0_end: got timeout expected last column within 200 cycles");
        end
        tick();
        n_checks++;
        if ({bus.rden, bus.de_out, bus.col} !== {4'b0, 1'b1, 5'(W - 1)}) begin
            n_fail++; $display("FAIL coin_adv: got rden %b de %b col %0d expected 0 1 %0d", bus.rden, bus.de_out, bus.col, W - 1);
        end
        bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
        n_checks++;
        if ({bus.wr_stall, bus.overflow} !== 2'b00) begin
            n_fail++; $display("FAIL coin_no_stall: got stall/ovf %b expected 00", {bus.wr_stall, bus.overflow});
        end
        tick();
        n_checks++;
        if (bus.rden !== 4'b1110) begin
            n_fail++; $display("FAIL coin_row1_rden: got %b expected 1110", bus.rden);
        end
        bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
        n_checks++;
        if ({bus.wr_stall, bus.de_out, bus.out_row} !== {1'b1, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL coin_counts: got stall %b de %b row %0d expected 1 1 1", bus.wr_stall, bus.de_out, bus.out_row);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
`ifndef LBUF_PAD_EN
        test_backpressure_and_reset();
        test_coincident();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
